arrow_lane_compositor: RTL and testbench

Consumer side of the dropper interface. Takes the position, 40×40 bitmap and hit bit from up to N_DROP droppers and composites them onto the VGA raster. It also tallies hits into a running score and drives a hit-flash indicator. It sits between the droppers and the color mapper, and runs on the pixel-rate clock.

---
 rtl/arrow_lane_compositor.sv | 172 +++++++++++++++++
 tb/tb_arrow_lane_compositor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_lane_compositor.sv
// arrow_lane_compositor
//   Composites up to N_DROP dropper sprites onto the VGA raster and keeps the
//   hit score / hit-flash indicator. Sprite positions and bitmaps are captured
//   once per frame so each frame is rendered from one consistent snapshot.
//
// Ports
//   Clk          pixel-rate clock
//   Reset        synchronous, active-high
//   frame_start  one-cycle strobe per frame (vertical blank)
//   dropX/dropY  packed 10-bit sprite top-left coordinates, channel i at [10i+9:10i]
//   arrow        packed SPR*SPR bitmaps, channel i at [SPR*SPR*(i+1)-1 : SPR*SPR*i]
//   score        per-channel hit level
//   DrawX/DrawY  current raster coordinate
//   pixel_on     an arrow pixel is set at the raster point from two cycles ago
//   pixel_id     lowest channel owning that pixel, 0 when pixel_on is low
//   hit_flash    high while the flash counter is nonzero
//   score_total  saturating count of score rising edges
module arrow_lane_compositor #(
  parameter int N_DROP    = 4,
  parameter int SPR       = 40,
  parameter int HIT_FLASH = 30
) (
  input  logic                                         Clk,
  input  logic                                         Reset,
  input  logic                                         frame_start,
  input  logic [N_DROP*10-1:0]                         dropX,
  input  logic [N_DROP*10-1:0]                         dropY,
  input  logic [N_DROP*SPR*SPR-1:0]                    arrow,
  input  logic [N_DROP-1:0]                            score,
  input  logic [9:0]                                   DrawX,
  input  logic [9:0]                                   DrawY,
  output logic                                         pixel_on,
  output logic [((N_DROP > 1) ? $clog2(N_DROP) : 1)-1:0] pixel_id,
  output logic                                         hit_flash,
  output logic [15:0]                                  score_total
);

  localparam int IDW  = (N_DROP > 1) ? $clog2(N_DROP) : 1;
  localparam int OW   = $clog2(SPR);
  localparam int BITS = SPR * SPR;
  localparam int AW   = $clog2(BITS);

  logic [9:0]        sX_q     [N_DROP];
  logic [9:0]        sY_q     [N_DROP];
  logic [BITS-1:0]   sArrow_q [N_DROP];

  logic [OW-1:0]     dx_q [N_DROP];
  logic [OW-1:0]     dy_q [N_DROP];
  logic [OW-1:0]     dx_d [N_DROP];
  logic [OW-1:0]     dy_d [N_DROP];
  logic [N_DROP-1:0] inbox_q, inbox_d;

  logic              pixelOn_q, pixelOn_d;
  logic [IDW-1:0]    pixelId_q, pixelId_d;
  logic [N_DROP-1:0] hit;

  logic [N_DROP-1:0] prevScore_q, rising;
  logic [15:0]       scoreTotal_q, scoreTotal_d;
  logic [7:0]        flashCnt_q, flashCnt_d;

  // Shadow copy of the dropper inputs, refreshed only on the frame strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_DROP; i++) begin
        sX_q[i]     <= '0;
        sY_q[i]     <= '0;
        sArrow_q[i] <= '0;
      end
    end else if (frame_start) begin
      for (int i = 0; i < N_DROP; i++) begin
        sX_q[i]     <= dropX[10*i +: 10];
        sY_q[i]     <= dropY[10*i +: 10];
        sArrow_q[i] <= arrow[BITS*i +: BITS];
      end
    end
  end

  // Stage 1: box test done in 11 bits so a sprite near the right/bottom edge
  // does not wrap around to column/row 0.
  always_comb begin
    for (int i = 0; i < N_DROP; i++) begin
      inbox_d[i] = ({1'b0, DrawX} >= {1'b0, sX_q[i]}) &&
                   ({1'b0, DrawX} <  ({1'b0, sX_q[i]} + 11'(SPR))) &&
                   ({1'b0, DrawY} >= {1'b0, sY_q[i]}) &&
                   ({1'b0, DrawY} <  ({1'b0, sY_q[i]} + 11'(SPR)));
      dx_d[i] = OW'(DrawX - sX_q[i]);
      dy_d[i] = OW'(DrawY - sY_q[i]);
    end
  end

  // Stage 2: bitmap lookup and fixed-priority owner select (lowest index wins).
  // The bitmap index is only meaningful when inbox is set, which also keeps it
  // below SPR*SPR.
  always_comb begin
    hit       = '0;
    pixelId_d = '0;
    for (int i = 0; i < N_DROP; i++) begin
      if (inbox_q[i]) begin
        hit[i] = sArrow_q[i][AW'(dy_q[i]) * AW'(SPR) + AW'(dx_q[i])];
      end
    end
    for (int i = N_DROP - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pixelId_d = IDW'(i);
      end
    end
    pixelOn_d = |hit;
  end

  // Two-stage raster pipeline registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_DROP; i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
      inbox_q   <= '0;
      pixelOn_q <= 1'b0;
      pixelId_q <= '0;
    end else begin
      for (int i = 0; i < N_DROP; i++) begin
        dx_q[i] <= dx_d[i];
        dy_q[i] <= dy_d[i];
      end
      inbox_q   <= inbox_d;
      pixelOn_q <= pixelOn_d;
      pixelId_q <= pixelId_d;
    end
  end

  // Score edges are judged strobe-to-strobe, so a level held across frames
  // counts once; all rising channels are added in the same cycle.
  always_comb begin
    logic [16:0] sum;
    rising = frame_start ? (score & ~prevScore_q) : '0;
    sum    = {1'b0, scoreTotal_q};
    for (int i = 0; i < N_DROP; i++) begin
      sum = sum + 17'(rising[i]);
    end
    scoreTotal_d = sum[16] ? 16'hFFFF : sum[15:0];

    flashCnt_d = flashCnt_q;
    if (frame_start) begin
      if (|rising) begin
        flashCnt_d = 8'(HIT_FLASH);
      end else if (flashCnt_q != 8'd0) begin
        flashCnt_d = flashCnt_q - 8'd1;
      end
    end
  end

  // Score, previous-level and flash state; all hold between strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prevScore_q  <= '0;
      scoreTotal_q <= '0;
      flashCnt_q   <= '0;
    end else begin
      if (frame_start) begin
        prevScore_q <= score;
      end
      scoreTotal_q <= scoreTotal_d;
      flashCnt_q   <= flashCnt_d;
    end
  end

  assign pixel_on    = pixelOn_q;
  assign pixel_id    = pixelId_q;
  assign hit_flash   = (flashCnt_q != 8'd0);
  assign score_total = scoreTotal_q;

endmodule

// File: tb/tb_arrow_lane_compositor.sv
// tb_arrow_lane_compositor
//   Drives arrow_lane_compositor with directed and $urandom stimulus and
//   compares every output against a coordinate-arithmetic reference model of
//   sprite compositing, score counting and the hit-flash countdown.
module tb_arrow_lane_compositor;

  localparam int NDROP = 4;
  localparam int SPR   = 40;
  localparam int HF    = 3;
  localparam int BITS  = SPR * SPR;

  logic                   Clk = 1'b0;
  logic                   Reset;
  logic                   frame_start;
  logic [NDROP*10-1:0]    dropX, dropY;
  logic [NDROP*BITS-1:0]  arrow;
  logic [NDROP-1:0]       score;
  logic [9:0]             DrawX, DrawY;
  logic                   pixel_on;
  logic [1:0]             pixel_id;
  logic                   hit_flash;
  logic [15:0]            score_total;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: frame snapshot, previous score levels, totals.
  int              mX [NDROP];
  int              mY [NDROP];
  logic [BITS-1:0] mArrow [NDROP];
  logic [NDROP-1:0] mPrev;
  int              mTotal;
  int              mFlash;

  int ptX[$];
  int ptY[$];

  arrow_lane_compositor #(
    .N_DROP(NDROP), .SPR(SPR), .HIT_FLASH(HF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .dropX(dropX), .dropY(dropY), .arrow(arrow), .score(score),
    .DrawX(DrawX), .DrawY(DrawY),
    .pixel_on(pixel_on), .pixel_id(pixel_id),
    .hit_flash(hit_flash), .score_total(score_total)
  );

  // Pixel clock, 10 time units per cycle.
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NDROP; i++) begin
      mX[i] = 0; mY[i] = 0; mArrow[i] = '0;
    end
    mPrev  = '0;
    mTotal = 0;
    mFlash = 0;
  endtask

  // Owner of raster point (x,y) in the model snapshot, -1 when nothing drawn.
  function automatic int refPixel(input int x, input int y);
    for (int i = 0; i < NDROP; i++) begin
      if (x >= mX[i] && x < mX[i] + SPR && y >= mY[i] && y < mY[i] + SPR) begin
        if (mArrow[i][(y - mY[i]) * SPR + (x - mX[i])]) return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [BITS-1:0] randomBitmap();
    logic [BITS-1:0] b;
    for (int k = 0; k < BITS / 32; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  task automatic setChannel(input int ch, input int x, input int y,
                            input logic [BITS-1:0] bm);
    dropX[10*ch +: 10]   = 10'(x);
    dropY[10*ch +: 10]   = 10'(y);
    arrow[BITS*ch +: BITS] = bm;
  endtask

  // One frame strobe with the currently driven inputs, mirrored in the model.
  task automatic applyStimulus();
    logic [NDROP-1:0] rising;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rising = score & ~mPrev;
    mTotal = mTotal + $countones(rising);
    if (mTotal > 65535) mTotal = 65535;
    if (rising != '0) mFlash = HF;
    else if (mFlash > 0) mFlash--;
    mPrev = score;
    for (int i = 0; i < NDROP; i++) begin
      mX[i]     = int'(dropX[10*i +: 10]);
      mY[i]     = int'(dropY[10*i +: 10]);
      mArrow[i] = arrow[BITS*i +: BITS];
    end
  endtask

  task automatic checkScore(input string tag);
    checkOutput({tag, "_total"}, 32'(score_total), 32'(mTotal));
    checkOutput({tag, "_flash"}, 32'(hit_flash), 32'(mFlash != 0));
  endtask

  // Streams the queued raster points one per cycle; each result is checked
  // exactly two cycles after its coordinate was presented.
  task automatic runScan(input string tag);
    int expOn[$];
    int expId[$];
    int r, n;
    n = ptX.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        DrawX = 10'(ptX[k]);
        DrawY = 10'(ptY[k]);
        r = refPixel(ptX[k], ptY[k]);
        expOn.push_back(r >= 0 ? 1 : 0);
        expId.push_back(r >= 0 ? r : 0);
      end
      tick();
      if (k >= 1) begin
        checkOutput({tag, "_on"}, 32'(pixel_on), 32'(expOn.pop_front()));
        checkOutput({tag, "_id"}, 32'(pixel_id), 32'(expId.pop_front()));
      end
    end
    ptX.delete();
    ptY.delete();
  endtask

  task automatic addPoint(input int x, input int y);
    ptX.push_back(x & 1023);
    ptY.push_back(y & 1023);
  endtask

  // Main sequence.
  initial begin
    logic [BITS-1:0] bm;
    int need;
    Reset = 1'b1; frame_start = 1'b0; dropX = '0; dropY = '0; arrow = '0;
    score = '0; DrawX = '0; DrawY = '0;
    modelReset();
    tick(); tick();
    Reset = 1'b0;
    checkOutput("rst_on", 32'(pixel_on), 32'd0);
    checkOutput("rst_id", 32'(pixel_id), 32'd0);
    checkScore("rst");

    $display("[TB] single sprite scan");
    bm = '0; bm[418] = 1'b1; bm[419] = 1'b1; bm[1099] = 1'b1;
    setChannel(0, 380, 100, bm);
    applyStimulus();
    addPoint(398, 110); addPoint(399, 110); addPoint(399, 127);
    addPoint(397, 110); addPoint(379, 100);
    runScan("single");

    $display("[TB] overlap priority");
    setChannel(1, 100, 100, '1);
    setChannel(3, 100, 100, '1);
    applyStimulus();
    addPoint(120, 120); addPoint(100, 100); addPoint(139, 139); addPoint(140, 120);
    runScan("overlap");

    $display("[TB] snapshot isolation");
    setChannel(0, 200, 100, bm);
    addPoint(398, 110); addPoint(218, 110);
    runScan("isoBefore");
    applyStimulus();
    addPoint(398, 110); addPoint(218, 110); addPoint(219, 127);
    runScan("isoAfter");

    $display("[TB] right/bottom edge sprites");
    setChannel(0, 1000, 1000, '1);
    setChannel(1, 1010, 5, '1);
    setChannel(2, 0, 0, '0);
    setChannel(3, 0, 0, '0);
    applyStimulus();
    addPoint(1023, 1023); addPoint(1000, 1000); addPoint(5, 1010);
    addPoint(5, 5); addPoint(1015, 10); addPoint(999, 1000);
    runScan("edge");

    $display("[TB] random sprites");
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < NDROP; i++)
        setChannel(i, $urandom_range(0, 1023), $urandom_range(0, 1023), randomBitmap());
      applyStimulus();
      for (int p = 0; p < 60; p++) begin
        int ch;
        ch = $urandom_range(0, NDROP - 1);
        addPoint(mX[ch] + $urandom_range(0, SPR + 3) - 2,
                 mY[ch] + $urandom_range(0, SPR + 3) - 2);
      end
      runScan("rand");
    end

    $display("[TB] score edges and flash");
    score = '0;
    for (int s = 0; s < 4; s++) begin
      applyStimulus();
      checkScore("clear");
    end
    score = 4'b0101;
    applyStimulus();
    checkScore("hit2");
    for (int s = 0; s < 5; s++) begin
      applyStimulus();
      checkScore("hold");
    end
    score = 4'b0000;
    applyStimulus();
    score = 4'b0001;
    applyStimulus();
    checkScore("reHit");
    applyStimulus();
    checkScore("flashDec");
    score = 4'b0011;
    applyStimulus();
    checkScore("reload");
    for (int s = 0; s < 4; s++) begin
      applyStimulus();
      checkScore("count");
    end

    $display("[TB] random score levels");
    for (int s = 0; s < 40; s++) begin
      score = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        checkScore("idle");
      end else begin
        applyStimulus();
        checkScore("rscore");
      end
    end

    $display("[TB] saturation");
    score = '0;
    applyStimulus();
    while (mTotal < 16'hFFFE) begin
      need  = 16'hFFFE - mTotal;
      score = (need >= 4) ? 4'hF : 4'((1 << need) - 1);
      applyStimulus();
      score = '0;
      applyStimulus();
    end
    checkScore("preSat");
    score = 4'b0111;
    applyStimulus();
    checkScore("sat");
    score = '0;
    applyStimulus();
    score = 4'hF;
    applyStimulus();
    checkScore("satHold");

    $display("[TB] reset mid-frame");
    setChannel(0, 300, 200, '1);
    applyStimulus();
    addPoint(310, 210);
    runScan("preRst");
    tick();
    checkOutput("preRst_on", 32'(pixel_on), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    modelReset();
    checkOutput("midRst_on", 32'(pixel_on), 32'd0);
    checkOutput("midRst_id", 32'(pixel_id), 32'd0);
    checkScore("midRst");
    addPoint(310, 210); addPoint(300, 200);
    runScan("postRst");

    Reset = 1'b1; frame_start = 1'b1; score = 4'hF;
    tick();
    Reset = 1'b0; frame_start = 1'b0;
    checkScore("rstStrobe");
    addPoint(310, 210);
    runScan("rstStrobe");
    applyStimulus();
    checkScore("afterRst");
    addPoint(310, 210); addPoint(299, 200);
    runScan("afterRst");

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
